de_video_rx: RTL

DE_VIDEO_RX -- requirements
Module: de_video_rx

---
 rtl/de_video_pkg.sv | 26 ++
 rtl/de_gap_counter.sv | 39 +++
 rtl/de_video_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/de_video_pkg.sv
// Shared definitions for the DE-mode video receiver and the panel timing generator.
// Holds the FSM state encoding, the RGB565 pixel type and the default panel geometry.
package de_video_pkg;

    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 480;
    localparam int VGAP_MIN_DEF = 512;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_SEEK  = 2'd0;
    localparam rx_state_t ST_BLANK = 2'd1;
    localparam rx_state_t ST_LINE  = 2'd2;
    localparam rx_state_t ST_HGAP  = 2'd3;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/de_gap_counter.sv
// Saturating counter of consecutive DE-low samples with a "threshold reached" flag.
module de_gap_counter
    import de_video_pkg::*;
#(
    parameter int THRESH = VGAP_MIN_DEF,
    parameter int W      = $clog2(THRESH + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_reached
);

    localparam logic [W-1:0] LIMIT = W'(THRESH);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_inc && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_reached = (count_q == LIMIT);

endmodule

// File: rtl/de_video_rx.sv
// DE-mode RGB565 receiver: recovers pixel coordinates from the data-enable pattern,
// checks frame geometry and reports lock. Input-to-output latency is two cycles.
module de_video_rx
    import de_video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int VGAP_MIN = VGAP_MIN_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_den,
    input  logic [4:0]  i_r,
    input  logic [5:0]  i_g,
    input  logic [4:0]  i_b,
    output logic        o_valid,
    output logic [15:0] o_pix,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_locked,
    output logic        o_err_hlen,
    output logic        o_err_vlen
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

    rx_state_t   state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        bad_q, bad_d;
    logic        locked_q, locked_d;

    logic        den_s_q, den_s_d;
    rgb565_t     pix_s_q, pix_s_d;
    logic        s_valid_q, s_valid_d;

    logic        valid_q, pix_valid_unused;
    logic [15:0] pix_q;
    logic [9:0]  ox_q, oy_q;
    logic        sof_q, eol_q, err_hlen_q, err_vlen_q;

    logic        emit, start, eol, err_hlen, err_vlen;
    logic [9:0]  emit_x, emit_y;
    logic        gap_done;

    assign pix_valid_unused = 1'b0;

    // The reset value of the input register is not a real sample, so it is not counted as a gap cycle.
    de_gap_counter #(.THRESH(VGAP_MIN)) u_gap (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (den_s_q),
        .i_inc     (!den_s_q && s_valid_q),
        .o_reached (gap_done)
    );

    always_comb begin
        den_s_d   = i_den;
        pix_s_d   = '{r: i_r, g: i_g, b: i_b};
        s_valid_d = 1'b1;
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bad_d     = bad_q;
        locked_d  = locked_q;
        emit      = 1'b0;
        start     = 1'b0;
        err_vlen  = 1'b0;
        emit_x    = '0;
        emit_y    = '0;

        case (state_q)
            ST_SEEK: begin
                if (gap_done) begin
                    if (den_s_q) start = 1'b1;
                    else         state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (den_s_q) start = 1'b1;
            end
            ST_LINE: begin
                if (den_s_q) begin
                    emit   = 1'b1;
                    emit_x = x_q;
                    emit_y = y_q;
                    x_d    = sat_inc10(x_q);
                end else begin
                    state_d = ST_HGAP;
                end
            end
            ST_HGAP: begin
                // A completed vertical gap closes the frame first; a DE-high in that same cycle opens the next one.
                if (gap_done) begin
                    err_vlen = (y_q != V_LAST);
                    if (!err_vlen && !bad_q) locked_d = 1'b1;
                    if (den_s_q) start = 1'b1;
                    else         state_d = ST_BLANK;
                end else if (den_s_q) begin
                    if (y_q == V_LAST) begin
                        err_vlen = 1'b1;
                        state_d  = ST_SEEK;
                    end else begin
                        emit    = 1'b1;
                        emit_y  = y_q + 10'd1;
                        y_d     = y_q + 10'd1;
                        x_d     = 10'd1;
                        state_d = ST_LINE;
                    end
                end
            end
            default: state_d = ST_SEEK;
        endcase

        if (start) begin
            emit    = 1'b1;
            emit_x  = '0;
            emit_y  = '0;
            x_d     = 10'd1;
            y_d     = '0;
            bad_d   = 1'b0;
            state_d = ST_LINE;
        end

        // The raw input is the next sample, so it tells whether the pixel being emitted ends its line.
        eol      = emit && !i_den;
        err_hlen = eol && (emit_x != H_LAST);
        if (err_hlen) bad_d = 1'b1;
        if (err_hlen || err_vlen) locked_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_SEEK;
            x_q        <= '0;
            y_q        <= '0;
            bad_q      <= 1'b0;
            locked_q   <= 1'b0;
            den_s_q    <= 1'b0;
            pix_s_q    <= '0;
            s_valid_q  <= 1'b0;
            valid_q    <= 1'b0;
            pix_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            err_hlen_q <= 1'b0;
            err_vlen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            bad_q      <= bad_d;
            locked_q   <= locked_d;
            den_s_q    <= den_s_d;
            pix_s_q    <= pix_s_d;
            s_valid_q  <= s_valid_d;
            valid_q    <= emit;
            pix_q      <= emit ? pix_s_q : 16'h0000;
            ox_q       <= emit_x;
            oy_q       <= emit_y;
            sof_q      <= start;
            eol_q      <= eol;
            err_hlen_q <= err_hlen;
            err_vlen_q <= err_vlen;
        end
    end

    assign o_valid    = valid_q | pix_valid_unused;
    assign o_pix      = pix_q;
    assign o_x        = ox_q;
    assign o_y        = oy_q;
    assign o_sof      = sof_q;
    assign o_eol      = eol_q;
    assign o_locked   = locked_q;
    assign o_err_hlen = err_hlen_q;
    assign o_err_vlen = err_vlen_q;

endmodule
